mem_port_arbiter: RTL

//  Shares one external memory bus between instruction fetch (IF) and data memory (DM) of the pipelined CPU.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and data memory
// Ports: clk/reset (sync, active-high); if_req/if_addr -> if_gnt/if_valid/if_rdata (fetch side);
// dm_req/dm_we/dm_size/dm_addr/dm_wdata -> dm_gnt/dm_valid/dm_rdata (data side);
// mem_req/mem_we/mem_addr/mem_be/mem_wdata <- mem_rdata/mem_ack (bus); misaligned pulse, sticky err.
module mem_port_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] DMEM_BASE = ADDR_W'(32'h8000_0000),
  parameter bit                DATA_PRIO = 1'b1,
  parameter int                TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [31:0]       dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              misaligned,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF} state_t;
  state_t          r_state;
  logic            r_rr;
  logic            r_we;
  logic [2:0]      r_size;
  logic [1:0]      r_off;
  logic [CW-1:0]   r_cnt;
  logic            w_busy, w_arb, w_dm_ok, w_if_ok, w_pick_dm, w_to, w_dm_mis, w_if_mis;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata, w_sh, w_ext;
  assign w_busy    = r_state != IDLE;
  assign w_arb     = !w_busy || mem_ack;
  // A side whose transfer is acking this cycle has not yet seen its valid, so its req is a hold-over.
  assign w_dm_ok   = dm_req && r_state != BUSY_DM;
  assign w_if_ok   = if_req && r_state != BUSY_IF;
  // r_rr=1 means DM was granted last and loses a tie in round-robin mode.
  assign w_pick_dm = w_dm_ok && (!w_if_ok || DATA_PRIO || !r_rr);
  assign dm_gnt    = w_arb && w_pick_dm;
  assign if_gnt    = w_arb && w_if_ok && !w_pick_dm;
  assign w_to      = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign w_dm_mis  = dm_size[1:0] == 2'b00 ? 1'b0 : dm_size[1:0] == 2'b01 ? dm_addr[0] : |dm_addr[1:0];
  assign w_if_mis  = |if_addr[1:0];
  assign w_be      = dm_size[1:0] == 2'b00 ? 4'b0001 << dm_addr[1:0] :
                     dm_size[1:0] == 2'b01 ? 4'b0011 << dm_addr[1:0] : 4'b1111;
  assign w_wdata   = dm_size[1:0] == 2'b00 ? {4{dm_wdata[7:0]}} :
                     dm_size[1:0] == 2'b01 ? {2{dm_wdata[15:0]}} : dm_wdata;
  assign w_sh      = mem_rdata >> {r_off, 3'b000};
  assign w_ext     = r_size[1:0] == 2'b00 ? {{24{~r_size[2] & w_sh[7]}}, w_sh[7:0]} :
                     r_size[1:0] == 2'b01 ? {{16{~r_size[2] & w_sh[15]}}, w_sh[15:0]} : mem_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr       <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      misaligned <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      misaligned <= 1'b0;
      if (w_busy) r_cnt <= r_cnt + 1'b1;
      if (w_busy && mem_ack) begin
        if (r_state == BUSY_DM) begin
          dm_valid <= 1'b1;
          dm_rdata <= r_we ? 32'h0 : w_ext;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end else if (w_busy && w_to) begin
        r_state <= IDLE;
        mem_req <= 1'b0;
        err     <= 1'b1;
        if (r_state == BUSY_DM) begin
          dm_valid <= 1'b1;
          dm_rdata <= '0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= '0;
        end
      end
      if (w_arb) begin
        r_state <= IDLE;
        mem_req <= 1'b0;
        if (dm_gnt) begin
          r_rr <= 1'b1;
          if (w_dm_mis) begin
            dm_valid   <= 1'b1;
            dm_rdata   <= '0;
            misaligned <= 1'b1;
          end else begin
            r_state   <= BUSY_DM;
            r_cnt     <= '0;
            r_we      <= dm_we;
            r_size    <= dm_size;
            r_off     <= dm_addr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= {dm_addr[ADDR_W-1:2], 2'b00} | DMEM_BASE;
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
          end
        end else if (if_gnt) begin
          r_rr <= 1'b0;
          if (w_if_mis) begin
            if_valid   <= 1'b1;
            if_rdata   <= '0;
            misaligned <= 1'b1;
          end else begin
            r_state   <= BUSY_IF;
            r_cnt     <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_be    <= 4'b1111;
            mem_wdata <= '0;
          end
        end
      end
    end
  end
endmodule
